// File: rtl/deinterleaver_if.sv
// Handshake bundle for the deinterleaver: serial coded bits in (channel order),
// deinterleaved bits out (original order) with index and end-of-block pulse.
interface deinterleaver_if;
  localparam int unsigned IDX_W = 9;

  logic             data_in;
  logic             valid_in;
  logic             ready_out;
  logic             data_out;
  logic             valid_out;
  logic             ready_in;
  logic [IDX_W-1:0] data_out_index;
  logic             block_done;

  // Deinterleaver side
  modport slave (
    input  data_in, valid_in, ready_in,
    output ready_out, data_out, valid_out, data_out_index, block_done
  );

  // Producer/consumer side
  modport master (
    output data_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out, data_out_index, block_done
  );
endinterface

// File: rtl/deinterleaver.sv
// Block deinterleaver for 192-bit QPSK blocks (16 columns): ping-pong bit banks,
// writes scattered in channel order, reads streamed out in original order.
module deinterleaver #(
  parameter int unsigned NCBPS = 192,
  parameter int unsigned D     = 16
) (
  input  logic           clk,
  input  logic           resetN,
  deinterleaver_if.slave bus
);
  localparam int unsigned ROWS   = NCBPS / D;
  localparam int unsigned A_W    = $clog2(ROWS);
  localparam int unsigned B_W    = $clog2(D);
  localparam int unsigned ADDR_W = $clog2(NCBPS);
  localparam int unsigned IDX_W  = 9;

  logic [A_W-1:0]    a_q;
  logic [B_W-1:0]    b_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              wr_bank_q;
  logic              rd_bank_q;
  logic [1:0]        full_q;
  logic              block_done_q;
  logic [NCBPS-1:0]  bank_q [2];

  logic              wr_fire_c;
  logic              rd_fire_c;
  logic              wr_last_c;
  logic              rd_last_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [1:0]        full_nxt_c;

  // Handshakes, block boundaries and write address k = 16a + b (b < 16, so a concat)
  always_comb begin
    wr_fire_c  = bus.valid_in && !full_q[wr_bank_q];
    rd_fire_c  = full_q[rd_bank_q] && bus.ready_in;
    wr_last_c  = (a_q == A_W'(ROWS - 1)) && (b_q == B_W'(D - 1));
    rd_last_c  = (rd_addr_q == ADDR_W'(NCBPS - 1));
    wr_addr_c  = {a_q, b_q};

    // A bank can only be written while empty and read while full, so set/clear never collide
    full_nxt_c = full_q;
    if (wr_fire_c && wr_last_c) full_nxt_c[wr_bank_q] = 1'b1;
    if (rd_fire_c && rd_last_c) full_nxt_c[rd_bank_q] = 1'b0;
  end

  // Bus outputs: handshake flags and read data come straight from state/storage
  always_comb begin
    bus.ready_out      = ~full_q[wr_bank_q];
    bus.valid_out      = full_q[rd_bank_q];
    bus.data_out       = bank_q[rd_bank_q][rd_addr_q];
    bus.data_out_index = IDX_W'(rd_addr_q);
    bus.block_done     = block_done_q;
  end

  // Counters, bank pointers and full flags
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      a_q          <= '0;
      b_q          <= '0;
      rd_addr_q    <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      full_q       <= '0;
      block_done_q <= 1'b0;
    end else begin
      block_done_q <= rd_fire_c && rd_last_c;
      full_q       <= full_nxt_c;

      if (wr_fire_c) begin
        if (a_q == A_W'(ROWS - 1)) begin
          a_q <= '0;
          b_q <= (b_q == B_W'(D - 1)) ? '0 : b_q + B_W'(1);
        end else begin
          a_q <= a_q + A_W'(1);
        end
        if (wr_last_c) wr_bank_q <= ~wr_bank_q;
      end

      if (rd_fire_c) begin
        rd_addr_q <= rd_last_c ? '0 : rd_addr_q + ADDR_W'(1);
        if (rd_last_c) rd_bank_q <= ~rd_bank_q;
      end
    end
  end

  // Bit storage carries no reset; the full flags gate its visibility
  always_ff @(posedge clk) begin
    if (wr_fire_c) bank_q[wr_bank_q][wr_addr_c] <= bus.data_in;
  end
endmodule

// File: doc/deinterleaver.md
DEINTERLEAVER -- requirements
Module: deinterleaver

Interface
REQ-001 Parameter NCBPS, default 192, coded bits per block; the design supports only 192.
REQ-002 Parameter D, default 16, interleaver column count; the design supports only 16. Ncpc=2 (QPSK), so s=1 and the second permutation is identity.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 resetN  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  1  received interleaved bit, arriving in channel order j.
REQ-006 valid_in  input  1  data_in is valid this cycle.
REQ-007 ready_out  output  1  block can accept data_in this cycle.
REQ-008 data_out  output  1  deinterleaved bit, in original order k.
REQ-009 valid_out  output  1  data_out is valid.
REQ-010 ready_in  input  1  downstream accepts data_out this cycle.
REQ-011 data_out_index  output  9  original index k (0..191) of the current data_out.
REQ-012 block_done  output  1  one-cycle pulse on acceptance of output bit k=191.

Function
REQ-013 Input transfer occurs when valid_in && ready_out; output transfer occurs when valid_out && ready_in.
REQ-014 Storage is two 192-bit banks (ping-pong), each with a full flag, plus a write-bank pointer and a read-bank pointer.
REQ-015 Write addressing uses nested counters a (0..11, inner) and b (0..15, outer); channel index j=12b+a; write address k=16a+b; no multiplier.
REQ-016 Each input transfer writes data_in to bank[wr_bank][k] and advances a; on a=11, a wraps to 0 and b increments; on a=11 and b=15, both wrap to 0.
REQ-017 On the input transfer with j=191, the same edge sets full[wr_bank] and toggles wr_bank.
REQ-018 ready_out = !full[wr_bank].
REQ-019 Read addressing uses counter rd_addr (0..191), incremented on each output transfer and wrapping 191->0.
REQ-020 valid_out = full[rd_bank]; data_out = bank[rd_bank][rd_addr] (combinational from storage); data_out_index = rd_addr.
REQ-021 On the output transfer with rd_addr=191, the same edge clears full[rd_bank], toggles rd_bank, and pulses block_done on that same cycle.
REQ-022 Latency: valid_out rises on the cycle after the input transfer with j=191.
REQ-023 Read and write of different banks in the same cycle are independent. A bank cleared at an edge may be written from the next cycle.
REQ-024 Throughput: with valid_in=1 and ready_in=1 continuously, one bit per cycle on each side. After the initial fill, ready_out never deasserts.
REQ-025 Backpressure: with ready_in=0, at most 384 bits are accepted, after which ready_out=0. data_out and data_out_index hold while valid_out && !ready_in.
REQ-026 valid_in while ready_out=0 is ignored; counters do not move.

Reset
REQ-027 resetN low, at any time including mid-block, asynchronously clears:
- a, b, rd_addr
- wr_bank, rd_bank
- both full flags
- block_done
REQ-028 During and after reset: ready_out=1, valid_out=0, data_out_index=0, block_done=0. Partial block contents are discarded; bank data bits need no reset.

Verification
REQ-029 Reset check: assert resetN=0 mid-stream -> ready_out=1, valid_out=0, data_out_index=0, block_done=0 immediately (asynchronously).
REQ-030 Single bit at j=1: send one block with data_in=1 only at j=1, ready_in=1 -> exactly one output 1, at data_out_index=16. Repeat with j=12 -> output 1 at index 1 only. Repeat with j=191 -> output 1 at index 191 only.
REQ-031 Golden comparison: feed 3 random blocks, each pre-interleaved with m=12*(k mod 16)+floor(k/16), back-to-back, ready_in=1 -> outputs equal the original bits in k order. ready_out stays 1 throughout. block_done pulses 3 times, 192 cycles apart.
REQ-032 Backpressure: ready_in=0, valid_in=1 continuously -> exactly 384 input transfers, then ready_out=0. Then set ready_in=1 -> ready_out returns to 1 on the cycle after the 192nd output transfer.
REQ-033 Stalls on both sides: random valid_in/ready_in gaps -> no bit lost or duplicated; data_out and data_out_index stable while stalled.
REQ-034 Reset mid-block: assert reset after 100 input bits, then send a full block -> output matches only the post-reset block.
